// File: rtl/cga_vram_arbiter_if.sv
// cga_vram_arbiter_if: ISA-side bus bundle between the CPU and the CGA VRAM arbiter.
// master = CPU/bus side (address, strobes, decode, write data); slave = arbiter (read data, dir, ready).
interface cga_vram_arbiter_if;
   logic [14:0] bus_a;
   logic        bus_memr_l;
   logic        bus_memw_l;
   logic        bus_mem_cs;
   logic [7:0]  bus_d;
   logic [7:0]  bus_out;
   logic        bus_dir;
   logic        bus_rdy;

   modport master (
      output bus_a, bus_memr_l, bus_memw_l, bus_mem_cs, bus_d,
      input  bus_out, bus_dir, bus_rdy
   );

   modport slave (
      input  bus_a, bus_memr_l, bus_memw_l, bus_mem_cs, bus_d,
      output bus_out, bus_dir, bus_rdy
   );
endinterface

// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: shares CGA video RAM between display fetches and ISA CPU accesses.
// Ports: clk, reset_l (sync, active-low); bus (ISA slave bundle: bus_a, bus_memr_l,
// bus_memw_l, bus_mem_cs, bus_d, bus_out, bus_dir, bus_rdy); disp_req/disp_a from the
// display sequencer; ram_a/ram_we_l/ram_din/ram_dout to the RAM; cpu_grant marks
// cycles the CPU owns the RAM. Macro CGA_SNOW_EN: CPU takes the RAM immediately
// (no slot wait), reproducing original CGA snow.
module cga_vram_arbiter #(
   parameter logic [4:0] WAIT_MAX     = 5'd24,
   parameter bit         USE_BUS_WAIT = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_l,
   cga_vram_arbiter_if.slave         bus,
   input  logic                      disp_req,
   input  logic [18:0]               disp_a,
   output logic [18:0]               ram_a,
   output logic                      ram_we_l,
   input  logic [7:0]                ram_din,
   output logic [7:0]                ram_dout,
   output logic                      cpu_grant
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SLOT,
      ACCESS,
      LATCH,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  memr_sync_q;
   logic [2:0]  memw_sync_q;
   logic [18:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        wr_q, wr_d;
   logic [4:0]  wait_q, wait_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  out_q, out_d;

   logic rd_fall;
   logic wr_fall;
   logic req;
   logic bus_idle;

   // [0],[1] form the synchroniser; [2] is the previous synced value for edge detect
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         memr_sync_q <= 3'b111;
         memw_sync_q <= 3'b111;
      end else begin
         memr_sync_q <= {memr_sync_q[1:0], bus.bus_memr_l};
         memw_sync_q <= {memw_sync_q[1:0], bus.bus_memw_l};
      end
   end

   assign rd_fall  = memr_sync_q[2] & ~memr_sync_q[1];
   assign wr_fall  = memw_sync_q[2] & ~memw_sync_q[1];
   assign req      = bus.bus_mem_cs & (rd_fall | wr_fall);
   assign bus_idle = memr_sync_q[1] & memw_sync_q[1];

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         wait_q  <= '0;
         rdy_q   <= 1'b1;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         wait_q  <= wait_d;
         rdy_q   <= rdy_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wr_d      = wr_q;
      wait_d    = wait_q;
      rdy_d     = rdy_q;
      out_d     = out_q;
      ram_a     = disp_a;
      ram_we_l  = 1'b1;
      ram_dout  = data_q;
      cpu_grant = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d = {4'h0, bus.bus_a};
               data_d = bus.bus_d;
               // simultaneous strobes resolve as a write
               wr_d   = wr_fall;
               wait_d = '0;
               rdy_d  = 1'b0;
`ifdef CGA_SNOW_EN
               state_d = ACCESS;
`else
               state_d = WAIT_SLOT;
`endif
            end
         end
         WAIT_SLOT: begin
            if (bus_idle) begin
               // CPU gave up the cycle before it was served
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else if (!disp_req || wait_q == WAIT_MAX) begin
               state_d = ACCESS;
            end else begin
               wait_d = wait_q + 5'd1;
            end
         end
         ACCESS: begin
            ram_a     = addr_q;
            ram_we_l  = ~wr_q;
            cpu_grant = 1'b1;
            state_d   = LATCH;
         end
         LATCH: begin
            ram_a     = addr_q;
            cpu_grant = 1'b1;
            if (!wr_q) begin
               out_d = ram_din;
            end
            rdy_d   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (bus_idle) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.bus_out = out_q;
   assign bus.bus_dir = bus.bus_mem_cs & ~bus.bus_memr_l;
   assign bus.bus_rdy = USE_BUS_WAIT ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb_cga_vram_arbiter: scoreboard bench for cga_vram_arbiter.
// Expected RAM writes and bus cycles are queued at stimulus time and checked by a monitor.
module tb_cga_vram_arbiter;

`ifdef CGA_SNOW_EN
   localparam int LAT_FREE = 2;
   localparam int LAT_FORCED = 2;
   localparam int LAT_DLY = 2;
   localparam int LAT_RST = 1;
`else
   localparam int LAT_FREE = 3;
   localparam int LAT_FORCED = 27;
   localparam int LAT_DLY = 8;
   localparam int LAT_RST = 2;
`endif

   typedef struct {
      int         lat;
      logic [7:0] out;
   } tx_t;

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk;
   logic        reset_l;
   logic        disp_req;
   logic [18:0] disp_a;
   logic [18:0] ram_a;
   logic        ram_we_l;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic        cpu_grant;

   logic [7:0]  mem [0:4095];

   cga_vram_arbiter_if bus_if ();

   cga_vram_arbiter dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .bus       (bus_if),
      .disp_req  (disp_req),
      .disp_a    (disp_a),
      .ram_a     (ram_a),
      .ram_we_l  (ram_we_l),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .cpu_grant (cpu_grant)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en = 0;
   logic [7:0] last_out = 8'h00;
   tx_t tx_q[$];
   wr_t wr_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      disp_a = 19'h01234;
      forever @(posedge clk) disp_a = disp_a + 19'h13;
   end

   assign ram_din = mem[ram_a[11:0]];

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h042] = 8'hC3;
      forever begin
         @(posedge clk);
         if (!ram_we_l) mem[ram_a[11:0]] = ram_dout;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   int low_cnt = 0;
   int g_cnt = 0;

   always @(negedge clk) begin : mon
      tx_t t;
      wr_t w;
      if (mon_en) begin
         if (!cpu_grant) chk("ram_a_disp", 32'(ram_a), 32'(disp_a));
         if (!ram_we_l) begin
            chk("wr_pending", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
               w = wr_q.pop_front();
               chk("wr_addr", 32'(ram_a), 32'(w.addr));
               chk("wr_data", 32'(ram_dout), 32'(w.data));
            end
         end
         if (!bus_if.bus_rdy) begin
            low_cnt++;
         end else if (low_cnt > 0) begin
            chk("tx_pending", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) begin
               t = tx_q.pop_front();
               chk("rdy_lat", 32'(low_cnt), 32'(t.lat));
               chk("bus_out", 32'(bus_if.bus_out), 32'(t.out));
            end
            low_cnt = 0;
         end
         if (cpu_grant) begin
            g_cnt++;
         end else if (g_cnt > 0) begin
            if (reset_l) chk("grant_len", 32'(g_cnt), 32'd2);
            g_cnt = 0;
         end
      end
   end

   task automatic cpu_start(input logic [14:0] a, input logic [7:0] d,
                            input bit wr, input bit rd, input int lat,
                            input bit do_ram);
      tx_t t;
      wr_t w;
      if (rd && !wr && do_ram) last_out = d;
      t.lat = lat;
      t.out = last_out;
      tx_q.push_back(t);
      if (wr && do_ram) begin
         w.addr = {4'h0, a};
         w.data = d;
         wr_q.push_back(w);
      end
      bus_if.bus_a      = a;
      bus_if.bus_d      = d;
      bus_if.bus_mem_cs = 1'b1;
      bus_if.bus_memw_l = !wr;
      bus_if.bus_memr_l = !rd;
      #1 chk("bus_dir", 32'(bus_if.bus_dir), 32'(rd));
   endtask

   task automatic wait_rdy_low();
      int n = 0;
      @(negedge clk);
      while (bus_if.bus_rdy && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (bus_if.bus_rdy) chk("rdy_low_to", 32'(bus_if.bus_rdy), 32'd0);
   endtask

   task automatic cpu_finish();
      int n = 0;
      while (!bus_if.bus_rdy && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (!bus_if.bus_rdy) chk("rdy_high_to", 32'(bus_if.bus_rdy), 32'd1);
      bus_if.bus_memr_l = 1'b1;
      bus_if.bus_memw_l = 1'b1;
      repeat (5) @(negedge clk);
      bus_if.bus_mem_cs = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_cycle(input logic [14:0] a, input logic [7:0] d,
                            input bit wr, input bit rd, input int lat);
      cpu_start(a, d, wr, rd, lat, 1'b1);
      wait_rdy_low();
      cpu_finish();
   endtask

   initial begin
      logic [14:0] a;
      logic [7:0]  d;
      int n;
      reset_l           = 1'b0;
      disp_req          = 1'b0;
      bus_if.bus_a      = '0;
      bus_if.bus_d      = '0;
      bus_if.bus_memr_l = 1'b1;
      bus_if.bus_memw_l = 1'b1;
      bus_if.bus_mem_cs = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(bus_if.bus_rdy), 32'd1);
      chk("rst_we", 32'(ram_we_l), 32'd1);
      chk("rst_grant", 32'(cpu_grant), 32'd0);
      chk("rst_out", 32'(bus_if.bus_out), 32'd0);
      chk("rst_ram_a", 32'(ram_a), 32'(disp_a));
      reset_l = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(negedge clk);

      // free slot write, then reads
      cpu_cycle(15'h0123, 8'h5A, 1'b1, 1'b0, LAT_FREE);
      cpu_cycle(15'h0042, 8'hC3, 1'b0, 1'b1, LAT_FREE);
      cpu_cycle(15'h0123, 8'h5A, 1'b0, 1'b1, LAT_FREE);
      cpu_cycle(15'h7FFF, 8'hA7, 1'b1, 1'b0, LAT_FREE);
      cpu_cycle(15'h7FFF, 8'hA7, 1'b0, 1'b1, LAT_FREE);

      // display holds the RAM: forced grant
      disp_req = 1'b1;
      cpu_cycle(15'h0200, 8'h3C, 1'b1, 1'b0, LAT_FORCED);
      disp_req = 1'b0;
      cpu_cycle(15'h0200, 8'h3C, 1'b0, 1'b1, LAT_FREE);

      // display releases the slot after five wait cycles
      disp_req = 1'b1;
      cpu_start(15'h0042, 8'hC3, 1'b0, 1'b1, LAT_DLY, 1'b1);
      wait_rdy_low();
      repeat (5) @(negedge clk);
      disp_req = 1'b0;
      cpu_finish();

      // both strobes together: write wins
      cpu_cycle(15'h0500, 8'h6E, 1'b1, 1'b1, LAT_FREE);
      cpu_cycle(15'h0500, 8'h6E, 1'b0, 1'b1, LAT_FREE);

      for (int i = 0; i < 4; i++) begin
         a = 15'h0400 + 15'(i * 16) + 15'($urandom_range(0, 15));
         d = 8'($urandom);
         cpu_cycle(a, d, 1'b1, 1'b0, LAT_FREE);
         cpu_cycle(a, d, 1'b0, 1'b1, LAT_FREE);
      end

`ifndef CGA_SNOW_EN
      // CPU abandons the cycle while waiting for a slot
      disp_req = 1'b1;
      cpu_start(15'h0300, 8'h11, 1'b1, 1'b0, 3, 1'b0);
      wait_rdy_low();
      bus_if.bus_memr_l = 1'b1;
      bus_if.bus_memw_l = 1'b1;
      repeat (6) @(negedge clk);
      bus_if.bus_mem_cs = 1'b0;
      disp_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_rdy", 32'(bus_if.bus_rdy), 32'd1);
      cpu_cycle(15'h0300, 8'h00, 1'b0, 1'b1, LAT_FREE);
`endif

      // reset in the middle of a write access
      last_out = 8'h00;
      cpu_start(15'h0155, 8'h99, 1'b1, 1'b0, LAT_RST, 1'b1);
      n = 0;
      @(negedge clk);
      while (ram_we_l && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk("rst_acc_we", 32'(ram_we_l), 32'd0);
      reset_l = 1'b0;
      @(negedge clk);
      chk("rst_acc_we1", 32'(ram_we_l), 32'd1);
      chk("rst_acc_rdy", 32'(bus_if.bus_rdy), 32'd1);
      chk("rst_acc_grant", 32'(cpu_grant), 32'd0);
      bus_if.bus_memr_l = 1'b1;
      bus_if.bus_memw_l = 1'b1;
      bus_if.bus_mem_cs = 1'b0;
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      repeat (4) @(negedge clk);

      cpu_cycle(15'h0042, 8'hC3, 1'b0, 1'b1, LAT_FREE);
      repeat (4) @(negedge clk);

      chk("wr_left", 32'(wr_q.size()), 32'd0);
      chk("tx_left", 32'(tx_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 5'd24: maximum cycles a CPU access waits for a free slot before it is forced.
REQ-002 SHALL have parameter USE_BUS_WAIT, default 1: 1 drives bus_rdy from the FSM, 0 ties bus_rdy to 1.
REQ-003 clk  in  1  system clock; one clock; all logic on its rising edge.
REQ-004 reset_l  in  1  reset, synchronous, active-low.
REQ-005 bus_a  in  15  CPU memory offset within the CGA window.
REQ-006 bus_memr_l / bus_memw_l  in  1 each  ISA memory read/write strobes, asynchronous.
REQ-007 bus_mem_cs  in  1  CGA framebuffer decode hit.
REQ-008 bus_d  in  8  CPU write data.
REQ-009 bus_out  out  8  registered CPU read data.
REQ-010 bus_dir  out  1  high when bus_mem_cs & ~bus_memr_l.
REQ-011 bus_rdy  out  1  ISA ready; low inserts wait states.
REQ-012 disp_req  in  1  display fetch owns RAM this cycle (from the sequencer).
REQ-013 disp_a  in  19  display fetch address.
REQ-014 ram_a  out  19  RAM address.
REQ-015 ram_we_l  out  1  RAM write enable, active-low.
REQ-016 ram_din  in  8  RAM read data.
REQ-017 ram_dout  out  8  RAM write data.
REQ-018 cpu_grant  out  1  high in ACCESS and LATCH.

Function
REQ-019 The FSM SHALL double-flop bus_memr_l and bus_memw_l before use.
REQ-020 A request SHALL be a synced strobe falling edge while bus_mem_cs=1; if both strobes fall together, the write SHALL win.
REQ-021 The FSM SHALL have states IDLE, WAIT_SLOT, ACCESS, LATCH, DONE.
REQ-022 IDLE->WAIT_SLOT on request: capture {4'h0,bus_a}, bus_d and the rd/wr flag; clear wait_cnt; bus_rdy<=0.
REQ-023 WAIT_SLOT->ACCESS when disp_req=0 or wait_cnt==WAIT_MAX (forced); otherwise wait_cnt+1, saturating at WAIT_MAX.
REQ-024 WAIT_SLOT->IDLE with no RAM access if both synced strobes are high (aborted cycle); bus_rdy<=1.
REQ-025 ACCESS SHALL last exactly 1 cycle: ram_a=captured address, ram_dout=captured data, ram_we_l=0 only for writes; ->LATCH.
REQ-026 LATCH SHALL last 1 cycle: ram_a held, ram_we_l=1; for reads bus_out<=ram_din at the cycle end; ->DONE.
REQ-027 DONE: bus_rdy=1; stay until both synced strobes are high, then ->IDLE.
REQ-028 ram_a SHALL equal disp_a in every state except ACCESS/LATCH.
REQ-029 Latency: request-edge to bus_rdy rise SHALL be 3 cycles with a free slot (WAIT_SLOT 1, ACCESS 1, LATCH 1).
REQ-030 A forced grant SHALL override disp_req; cpu_grant marks the corrupted fetch.
REQ-031 bus_out SHALL hold its value between reads.
REQ-032 With USE_BUS_WAIT=0, bus_rdy SHALL be constant 1 and the FSM SHALL otherwise be unchanged.

Reset
REQ-033 With reset_l=0 at a clock edge: state=IDLE, bus_rdy=1, ram_we_l=1, cpu_grant=0, bus_out=8'h00, wait_cnt=0, sync flops=1.
REQ-034 Reset SHALL abort any in-flight access, including during ACCESS, with no further RAM write.

Configuration
REQ-035 Macro CGA_SNOW_EN defined: IDLE SHALL go directly to ACCESS on request, ignoring disp_req (authentic snow; 2-cycle latency).
REQ-036 Macro CGA_SNOW_EN undefined: the slot-waiting behaviour of REQ-023 applies.

Verification
REQ-037 disp_req=0, write to 0x0123 with 0x5A -> exactly one cycle with ram_we_l=0, ram_a=0x00123, ram_dout=0x5A; bus_rdy low for 3 cycles.
REQ-038 RAM 0x00042=0xC3, read to 0x0042 -> bus_out=0xC3 and bus_rdy=1 three cycles after the edge.
REQ-039 disp_req held 1, WAIT_MAX=24 -> forced ACCESS after 24 waits; cpu_grant=1 for 2 cycles.
REQ-040 disp_req=1 for 5 cycles, then 0 -> ACCESS in the cycle after disp_req falls; ram_a=disp_a throughout the wait.
REQ-041 reset_l=0 during ACCESS of a write -> next cycle IDLE, ram_we_l=1, bus_rdy=1; no second write.
REQ-042 CGA_SNOW_EN defined, disp_req=1 -> write occurs 1 cycle after the edge; bus_rdy low 2 cycles.
